feed_scheduler: RTL and testbench

Sequences the pet feeder's single food outlet.
- Arbitrates between manual pour requests and a periodic interval schedule.
- Times each portion and enforces a cooldown between portions.
- Counts portions and locks the outlet when the per-refill limit is reached.
- Sits between the keypad/option decode and the food_switch actuator, replacing ad-hoc OR-ing of counter outputs.

---
 rtl/feed_scheduler.sv | 169 ++++++++++++++++
 tb/tb_feed_scheduler.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/feed_scheduler.sv
// rtl/feed_scheduler.sv - food outlet sequencer: manual/schedule arbitration, portion timing, cooldown, lockout
// Optional feature: define PORTION_CFG_EN to add cfg_portion, a load-time override of the portion length.
module feed_scheduler #(
  parameter int unsigned PORTION_TICKS  = 10,
  parameter int unsigned COOLDOWN_TICKS = 20,
  parameter int unsigned MAX_FEEDS      = 8,
  parameter int unsigned FEED_CNT_W     = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  tick,
  input  logic [15:0]           cfg_interval,
  input  logic                  cfg_load,
  input  logic                  sched_en,
  input  logic                  manual_req,
  input  logic                  stop_req,
  input  logic                  refill,
`ifdef PORTION_CFG_EN
  input  logic [3:0]            cfg_portion,
`endif
  output logic                  food_switch,
  output logic                  busy,
  output logic [1:0]            grant_src,
  output logic [FEED_CNT_W-1:0] feeds_done,
  output logic                  limit_hit
);

  typedef enum logic [1:0] {IDLE, POUR, COOLDOWN, LOCKED} state_t;

  localparam logic [15:0]           PORTION_LEN = 16'(PORTION_TICKS);
  localparam logic [15:0]           COOL_LAST   = 16'(COOLDOWN_TICKS - 1);
  localparam logic [FEED_CNT_W-1:0] FEED_LIMIT  = FEED_CNT_W'(MAX_FEEDS);
  localparam logic [FEED_CNT_W-1:0] FEED_SAT    = {FEED_CNT_W{1'b1}};

  state_t                state, state_nxt;
  logic [15:0]           interval_q, interval_nxt;
  logic [15:0]           int_cnt, int_cnt_nxt;
  logic [15:0]           por_cnt, por_cnt_nxt;
  logic [15:0]           cool_cnt, cool_cnt_nxt;
  logic                  man_pend, man_pend_nxt;
  logic                  sched_pend, sched_pend_nxt;
  logic [FEED_CNT_W-1:0] feeds, feeds_nxt;
  logic [1:0]            grant_q, grant_nxt;
  logic                  expire;
  logic [15:0]           plen;

`ifdef PORTION_CFG_EN
  logic [3:0] portion_q, portion_nxt;
  assign portion_nxt = cfg_load ? cfg_portion : portion_q;
  assign plen        = (portion_q != 4'd0) ? {12'd0, portion_q} : PORTION_LEN;

  always_ff @(posedge clock) begin
    if (reset) portion_q <= 4'd0;
    else       portion_q <= portion_nxt;
  end
`else
  assign plen = PORTION_LEN;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      interval_q <= '0;
      int_cnt    <= '0;
      por_cnt    <= '0;
      cool_cnt   <= '0;
      man_pend   <= 1'b0;
      sched_pend <= 1'b0;
      feeds      <= '0;
      grant_q    <= 2'b00;
    end else begin
      state      <= state_nxt;
      interval_q <= interval_nxt;
      int_cnt    <= int_cnt_nxt;
      por_cnt    <= por_cnt_nxt;
      cool_cnt   <= cool_cnt_nxt;
      man_pend   <= man_pend_nxt;
      sched_pend <= sched_pend_nxt;
      feeds      <= feeds_nxt;
      grant_q    <= grant_nxt;
    end
  end

  always_comb begin
    expire         = 1'b0;
    interval_nxt   = interval_q;
    int_cnt_nxt    = int_cnt;
    man_pend_nxt   = man_pend;
    sched_pend_nxt = sched_pend;
    state_nxt      = state;
    grant_nxt      = grant_q;
    por_cnt_nxt    = por_cnt;
    cool_cnt_nxt   = cool_cnt;
    feeds_nxt      = refill ? '0 : feeds;

    // Interval timer: a load restarts the period; lockout parks it at zero.
    if (cfg_load) begin
      interval_nxt = cfg_interval;
      int_cnt_nxt  = '0;
    end else if (state == LOCKED) begin
      int_cnt_nxt = '0;
    end else if (tick && sched_en && (interval_q != 16'd0)) begin
      if (int_cnt == interval_q - 16'd1) begin
        int_cnt_nxt = '0;
        expire      = 1'b1;
      end else begin
        int_cnt_nxt = int_cnt + 16'd1;
      end
    end

    if ((state == IDLE) || (state == COOLDOWN)) begin
      if (stop_req) begin
        man_pend_nxt   = 1'b0;
        sched_pend_nxt = 1'b0;
      end else begin
        if (manual_req) man_pend_nxt = 1'b1;
        if (expire)     sched_pend_nxt = 1'b1;
      end
    end else begin
      man_pend_nxt   = 1'b0;
      sched_pend_nxt = 1'b0;
    end

    case (state)
      IDLE: begin
        if (!stop_req && (man_pend || sched_pend)) begin
          state_nxt      = POUR;
          grant_nxt      = man_pend ? 2'b01 : 2'b10;
          man_pend_nxt   = 1'b0;
          sched_pend_nxt = 1'b0;
          por_cnt_nxt    = '0;
          if (refill)                 feeds_nxt = FEED_CNT_W'(1);
          else if (feeds != FEED_SAT) feeds_nxt = feeds + FEED_CNT_W'(1);
        end
      end
      POUR: begin
        if (stop_req || (tick && (por_cnt == plen - 16'd1))) begin
          state_nxt    = COOLDOWN;
          grant_nxt    = 2'b00;
          por_cnt_nxt  = '0;
          cool_cnt_nxt = '0;
        end else if (tick) begin
          por_cnt_nxt = por_cnt + 16'd1;
        end
      end
      COOLDOWN: begin
        if (tick) begin
          if (cool_cnt == COOL_LAST) begin
            cool_cnt_nxt = '0;
            state_nxt    = (!refill && (feeds == FEED_LIMIT)) ? LOCKED : IDLE;
          end else begin
            cool_cnt_nxt = cool_cnt + 16'd1;
          end
        end
      end
      LOCKED: begin
        if (refill) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign food_switch = (state == POUR);
  assign busy        = (state != IDLE);
  assign limit_hit   = (state == LOCKED);
  assign grant_src   = grant_q;
  assign feeds_done  = feeds;

endmodule

// File: tb/tb_feed_scheduler.sv
// tb/tb_feed_scheduler.sv - scoreboard bench for feed_scheduler (PORTION 4, COOLDOWN 3, MAX_FEEDS 2)
module tb_feed_scheduler;

  typedef struct packed {
    logic [1:0]  grant;
    logic [3:0]  feeds;
    logic [7:0]  len;
    logic [31:0] start;
  } por_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b1;
  logic [15:0] cfg_interval = 16'd0;
  logic        cfg_load = 1'b0;
  logic        sched_en = 1'b0;
  logic        manual_req = 1'b0;
  logic        stop_req = 1'b0;
  logic        refill = 1'b0;
`ifdef PORTION_CFG_EN
  logic [3:0]  cfg_portion = 4'd0;
`endif
  logic        food_switch, busy, limit_hit;
  logic [1:0]  grant_src;
  logic [3:0]  feeds_done;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  por_t exp_q[$];
  por_t obs_q[$];
  por_t cur = '0;
  logic prev_food = 1'b0;

  feed_scheduler #(
    .PORTION_TICKS(4), .COOLDOWN_TICKS(3), .MAX_FEEDS(2), .FEED_CNT_W(4)
  ) dut (
    .clock(clock), .reset(reset), .tick(tick),
    .cfg_interval(cfg_interval), .cfg_load(cfg_load), .sched_en(sched_en),
    .manual_req(manual_req), .stop_req(stop_req), .refill(refill),
`ifdef PORTION_CFG_EN
    .cfg_portion(cfg_portion),
`endif
    .food_switch(food_switch), .busy(busy), .grant_src(grant_src),
    .feeds_done(feeds_done), .limit_hit(limit_hit)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Portion monitor: one record per food_switch high period.
  always @(negedge clock) begin
    if (food_switch === 1'b1) begin
      if (!prev_food) begin
        cur.grant = grant_src;
        cur.feeds = feeds_done;
        cur.len   = 8'd1;
        cur.start = cyc;
      end else begin
        cur.len = cur.len + 8'd1;
      end
    end else if (prev_food) begin
      obs_q.push_back(cur);
    end
    prev_food = (food_switch === 1'b1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic string fmt(input por_t p);
    return $sformatf("grant=%0d feeds=%0d len=%0d start=%0d", p.grant, p.feeds, p.len, p.start);
  endfunction

  function automatic por_t mk(input logic [1:0] g, input int f, input int l, input int s);
    por_t p;
    p.grant = g;
    p.feeds = 4'(f);
    p.len   = 8'(l);
    p.start = 32'(s);
    return p;
  endfunction

  task automatic get_obs(output logic ok, output por_t o, output por_t e);
    int n = 0;
    ok = 1'b0;
    o  = '0;
    e  = '0;
    while (obs_q.size() == 0 && n < 200) begin
      step(1);
      n++;
    end
    if (obs_q.size() != 0 && exp_q.size() != 0) begin
      ok = 1'b1;
      o  = obs_q.pop_front();
      e  = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(3);
    checks++;
    if ({food_switch, busy, grant_src, feeds_done, limit_hit} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000000", {food_switch, busy, grant_src, feeds_done, limit_hit});
    end
    reset = 1'b0;
    step(2);
    checks++;
    if (busy !== 1'b0 || food_switch !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b food=%b expected 0 0", busy, food_switch);
    end
  endtask

  task automatic test_manual();
    int d;
    logic ok;
    por_t o, e;
    d = cyc;
    manual_req = 1'b1;
    step(1);
    manual_req = 1'b0;
    exp_q.push_back(mk(2'b01, 1, 4, d + 2));
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL manual_flag_idle: busy=%b expected 0", busy); end
    step(1);
    checks++;
    if ({food_switch, busy, grant_src, feeds_done} !== {1'b1, 1'b1, 2'b01, 4'd1}) begin
      errors++;
      $display("FAIL manual_grant: food=%b busy=%b grant=%b feeds=%0d expected 1 1 01 1", food_switch, busy, grant_src, feeds_done);
    end
    step(6);
    checks++;
    if (busy !== 1'b1 || food_switch !== 1'b0) begin errors++; $display("FAIL manual_cooldown: busy=%b food=%b expected 1 0", busy, food_switch); end
    step(1);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL manual_cooldown_end: busy=%b expected 0", busy); end
    get_obs(ok, o, e);
    checks++;
    if (!ok) begin errors++; $display("FAIL manual_portion: got none expected %s", fmt(e)); end
    else if (o !== e) begin errors++; $display("FAIL manual_portion: got %s expected %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_schedule();
    int L;
    logic ok;
    por_t o, e;
    cfg_interval = 16'd6;
    cfg_load = 1'b1;
    sched_en = 1'b1;
    refill = 1'b1;
    L = cyc + 1;
    step(1);
    exp_q.push_back(mk(2'b10, 1, 4, L + 7));
    exp_q.push_back(mk(2'b10, 1, 4, L + 15));
    exp_q.push_back(mk(2'b10, 1, 4, L + 25));
    for (int k = 1; k <= 34; k++) begin
      refill = (k == 8 || k == 16 || k == 26);
      cfg_load = (k == 26);
      if (k == 26) cfg_interval = 16'd0;
      step(1);
    end
    refill = 1'b0;
    cfg_load = 1'b0;
    sched_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      get_obs(ok, o, e);
      checks++;
      if (!ok) begin errors++; $display("FAIL sched_portion%0d: got none expected %s", i, fmt(e)); end
      else if (o !== e) begin errors++; $display("FAIL sched_portion%0d: got %s expected %s", i, fmt(o), fmt(e)); end
    end
    checks++;
    if (obs_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL sched_dropped_expiry: extra=%0d busy=%b expected 0 0", obs_q.size(), busy);
    end
  endtask

  task automatic test_simultaneous();
    int L;
    logic ok;
    por_t o, e;
    cfg_interval = 16'd6;
    cfg_load = 1'b1;
    sched_en = 1'b1;
    refill = 1'b1;
    L = cyc + 1;
    step(1);
    cfg_load = 1'b0;
    refill = 1'b0;
    exp_q.push_back(mk(2'b01, 1, 4, L + 7));
    step(5);
    manual_req = 1'b1;
    step(1);
    manual_req = 1'b0;
    cfg_interval = 16'd0;
    cfg_load = 1'b1;
    step(1);
    cfg_load = 1'b0;
    sched_en = 1'b0;
    get_obs(ok, o, e);
    checks++;
    if (!ok) begin errors++; $display("FAIL simul_portion: got none expected %s", fmt(e)); end
    else if (o !== e) begin errors++; $display("FAIL simul_portion: got %s expected %s", fmt(o), fmt(e)); end
    step(10);
    checks++;
    if (obs_q.size() != 0 || feeds_done !== 4'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL simul_single: extra=%0d feeds=%0d busy=%b expected 0 1 0", obs_q.size(), feeds_done, busy);
    end
  endtask

  task automatic test_stop();
    int S;
    logic ok;
    por_t o, e;
    refill = 1'b1;
    manual_req = 1'b1;
    S = cyc + 1;
    step(1);
    refill = 1'b0;
    manual_req = 1'b0;
    exp_q.push_back(mk(2'b01, 1, 2, S + 1));
    exp_q.push_back(mk(2'b01, 2, 4, S + 7));
    step(2);
    stop_req = 1'b1;
    step(1);
    stop_req = 1'b0;
    checks++;
    if (food_switch !== 1'b0 || busy !== 1'b1 || grant_src !== 2'b00) begin
      errors++;
      $display("FAIL stop_abort: food=%b busy=%b grant=%b expected 0 1 00", food_switch, busy, grant_src);
    end
    manual_req = 1'b1;
    step(1);
    manual_req = 1'b0;
    step(1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL stop_cooldown_len: busy=%b expected 1", busy); end
    step(1);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL stop_cooldown_end: busy=%b expected 0", busy); end
    for (int i = 0; i < 2; i++) begin
      get_obs(ok, o, e);
      checks++;
      if (!ok) begin errors++; $display("FAIL stop_portion%0d: got none expected %s", i, fmt(e)); end
      else if (o !== e) begin errors++; $display("FAIL stop_portion%0d: got %s expected %s", i, fmt(o), fmt(e)); end
    end
  endtask

  task automatic test_lockout();
    int n = 0;
    int d;
    logic ok;
    por_t o, e;
    while (limit_hit !== 1'b1 && n < 20) begin step(1); n++; end
    checks++;
    if (limit_hit !== 1'b1 || feeds_done !== 4'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL lock_enter: limit=%b feeds=%0d busy=%b expected 1 2 1", limit_hit, feeds_done, busy);
    end
    manual_req = 1'b1;
    step(1);
    manual_req = 1'b0;
    step(10);
    checks++;
    if (obs_q.size() != 0 || limit_hit !== 1'b1 || food_switch !== 1'b0) begin
      errors++;
      $display("FAIL lock_ignore: portions=%0d limit=%b food=%b expected 0 1 0", obs_q.size(), limit_hit, food_switch);
    end
    refill = 1'b1;
    step(1);
    refill = 1'b0;
    checks++;
    if (limit_hit !== 1'b0 || busy !== 1'b0 || feeds_done !== 4'd0) begin
      errors++;
      $display("FAIL lock_refill: limit=%b busy=%b feeds=%0d expected 0 0 0", limit_hit, busy, feeds_done);
    end
    d = cyc;
    manual_req = 1'b1;
    step(1);
    manual_req = 1'b0;
    exp_q.push_back(mk(2'b01, 1, 4, d + 2));
    get_obs(ok, o, e);
    checks++;
    if (!ok) begin errors++; $display("FAIL lock_after_refill: got none expected %s", fmt(e)); end
    else if (o !== e) begin errors++; $display("FAIL lock_after_refill: got %s expected %s", fmt(o), fmt(e)); end
    n = 0;
    while (busy !== 1'b0 && n < 20) begin step(1); n++; end
  endtask

  task automatic test_reset_mid_pour();
    int S;
    logic ok;
    por_t o, e;
    manual_req = 1'b1;
    S = cyc + 1;
    step(1);
    manual_req = 1'b0;
    exp_q.push_back(mk(2'b01, 2, 2, S + 1));
    step(2);
    reset = 1'b1;
    step(1);
    checks++;
    if ({food_switch, busy, grant_src, feeds_done, limit_hit} !== 9'd0) begin
      errors++;
      $display("FAIL reset_mid_pour: got %b expected 000000000", {food_switch, busy, grant_src, feeds_done, limit_hit});
    end
    reset = 1'b0;
    get_obs(ok, o, e);
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_cut_portion: got none expected %s", fmt(e)); end
    else if (o !== e) begin errors++; $display("FAIL reset_cut_portion: got %s expected %s", fmt(o), fmt(e)); end
  endtask

`ifdef PORTION_CFG_EN
  task automatic test_portion_cfg();
    int C;
    logic ok;
    por_t o, e;
    cfg_portion = 4'd2;
    cfg_interval = 16'd0;
    cfg_load = 1'b1;
    manual_req = 1'b1;
    C = cyc + 1;
    step(1);
    cfg_load = 1'b0;
    manual_req = 1'b0;
    exp_q.push_back(mk(2'b01, 1, 2, C + 1));
    get_obs(ok, o, e);
    checks++;
    if (!ok) begin errors++; $display("FAIL portion_cfg: got none expected %s", fmt(e)); end
    else if (o !== e) begin errors++; $display("FAIL portion_cfg: got %s expected %s", fmt(o), fmt(e)); end
  endtask
`endif

  initial begin
    step(1);
    test_reset();
    test_manual();
    test_schedule();
    test_simultaneous();
    test_stop();
    test_lockout();
    test_reset_mid_pour();
`ifdef PORTION_CFG_EN
    test_portion_cfg();
`endif
    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
